// File: rtl/tmc_dbg_scan_pkg.sv
// Shared types and constants for the Nios II debug virtual-JTAG scan master.
// Optional build macro used by the top: TMC_DBG_SCAN_LOOPBACK_EN.
package tmc_dbg_scan_pkg;

  localparam int DEF_SR_W = 38;
  localparam int DEF_IR_W = 2;

  localparam logic [1:0] IR_OCIMEM    = 2'b00;
  localparam logic [1:0] IR_TRACEMEM  = 2'b01;
  localparam logic [1:0] IR_BREAK     = 2'b10;
  localparam logic [1:0] IR_TRACECTRL = 2'b11;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    UIR  = 3'd1,
    CDR  = 3'd2,
    SDR  = 3'd3,
    UDR  = 3'd4,
    RTI  = 3'd5,
    RESP = 3'd6
  } scan_state_e;

  // True for the states that drive tck and a virtual-state strobe.
  function automatic logic in_scan(input scan_state_e st);
    case (st)
      UIR, CDR, SDR, UDR, RTI: in_scan = 1'b1;
      default:                 in_scan = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/tmc_dbg_tck_gen.sv
// JTAG clock generator: tck low for TCK_DIV clks, then high for TCK_DIV clks,
// running only while en is high; idles low.
module tmc_dbg_tck_gen #(
  parameter int TCK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tck,
  output logic tck_fall_phase,
  output logic tck_pre_rise
);

  localparam int POS_W = $clog2(2 * TCK_DIV);
  localparam logic [POS_W-1:0] POS_PRE  = POS_W'(TCK_DIV - 1);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(2 * TCK_DIV - 1);

  logic [POS_W-1:0] pos_r;
  logic             tck_r;

  // Position within the tck period and the registered tck level.
  always_ff @(posedge clk) begin
    if (reset || !en) begin
      pos_r <= {POS_W{1'b0}};
      tck_r <= 1'b0;
    end else begin
      if (pos_r == POS_LAST) pos_r <= {POS_W{1'b0}};
      else                   pos_r <= pos_r + POS_W'(1);
      if (pos_r == POS_PRE)       tck_r <= 1'b1;
      else if (pos_r == POS_LAST) tck_r <= 1'b0;
    end
  end

  // tck_fall_phase marks the clk whose closing edge opens the next low phase,
  // so registers loaded on it change on the first clk of that low phase.
  assign tck            = tck_r;
  assign tck_fall_phase = en && (pos_r == POS_LAST);
  assign tck_pre_rise   = en && (pos_r == POS_PRE);

endmodule

// File: rtl/tmc_dbg_scan_master.sv
// Host-side virtual-JTAG scan initiator: UIR, CDR, SR_W x SDR, UDR, RTI, response.
// Define TMC_DBG_SCAN_LOOPBACK_EN to add the loopback input (tdi fed back as tdo).
module tmc_dbg_scan_master
  import tmc_dbg_scan_pkg::*;
#(
  parameter int SR_W       = DEF_SR_W,
  parameter int IR_W       = DEF_IR_W,
  parameter int TCK_DIV    = 2,
  parameter int RTI_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [IR_W-1:0] cmd_ir,
  input  logic [SR_W-1:0] cmd_data,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [SR_W-1:0] rsp_data,
`ifdef TMC_DBG_SCAN_LOOPBACK_EN
  input  logic            loopback,
`endif
  output logic            tck,
  output logic            tdi,
  input  logic            tdo,
  output logic [IR_W-1:0] ir_in,
  output logic            vs_uir,
  output logic            vs_cdr,
  output logic            vs_sdr,
  output logic            vs_udr,
  output logic            jtag_state_rti,
  output logic            busy
);

  localparam int BIT_W = $clog2(SR_W);
  localparam int RTI_W = (RTI_CYCLES > 1) ? $clog2(RTI_CYCLES) : 1;

  scan_state_e     state_r, state_nxt_s;
  logic [SR_W-1:0] sr_r, rsp_data_r;
  logic [IR_W-1:0] ir_r;
  logic [BIT_W-1:0] bit_cnt_r;
  logic [RTI_W-1:0] rti_cnt_r;
  logic tdi_r, uir_r, cdr_r, sdr_r, udr_r, rti_r, busy_r, rsp_valid_r;
  logic drive_s, sample_s, sample_bit_s, cmd_ready_s, accept_s;
  logic last_bit_s, last_rti_s;

  tmc_dbg_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck_gen (
    .clk            (clk),
    .reset          (reset),
    .en             (busy_r),
    .tck            (tck),
    .tck_fall_phase (drive_s),
    .tck_pre_rise   (sample_s)
  );

  // RESP lasts one clk and behaves like IDLE, so a command can follow at once.
  assign cmd_ready_s = ((state_r == IDLE) || (state_r == RESP)) && (!rsp_valid_r || rsp_ready);
  assign accept_s    = cmd_valid && cmd_ready_s;
  assign last_bit_s  = (bit_cnt_r == BIT_W'(SR_W - 1));
  assign last_rti_s  = (rti_cnt_r == RTI_W'(RTI_CYCLES - 1));

`ifdef TMC_DBG_SCAN_LOOPBACK_EN
  logic lb_r;

  // Loopback mode is frozen for the whole scan at command accept.
  always_ff @(posedge clk) begin
    if (reset)         lb_r <= 1'b0;
    else if (accept_s) lb_r <= loopback;
  end

  assign sample_bit_s = lb_r ? tdi_r : tdo;
`else
  assign sample_bit_s = tdo;
`endif

  // Scan state register.
  always_ff @(posedge clk) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_nxt_s;
  end

  // Next-state logic; scan states advance only at tck period boundaries.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE, RESP: state_nxt_s = accept_s ? UIR : IDLE;
      UIR:        state_nxt_s = drive_s ? CDR : UIR;
      CDR:        state_nxt_s = drive_s ? SDR : CDR;
      SDR:        state_nxt_s = (drive_s && last_bit_s) ? UDR : SDR;
      UDR:        state_nxt_s = drive_s ? RTI : UDR;
      RTI:        state_nxt_s = (drive_s && last_rti_s) ? RESP : RTI;
      default:    state_nxt_s = IDLE;
    endcase
  end

  // Slave-facing outputs, decoded from the next state so they move with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      uir_r  <= 1'b0;
      cdr_r  <= 1'b0;
      sdr_r  <= 1'b0;
      udr_r  <= 1'b0;
      rti_r  <= 1'b0;
      busy_r <= 1'b0;
      tdi_r  <= 1'b0;
      ir_r   <= {IR_W{1'b0}};
    end else begin
      uir_r  <= (state_nxt_s == UIR);
      cdr_r  <= (state_nxt_s == CDR);
      sdr_r  <= (state_nxt_s == SDR);
      udr_r  <= (state_nxt_s == UDR);
      rti_r  <= (state_nxt_s == RTI);
      busy_r <= in_scan(state_nxt_s);
      if (drive_s)  tdi_r <= (state_nxt_s == SDR) ? sr_r[0] : 1'b0;
      if (accept_s) ir_r  <= cmd_ir;
    end
  end

  // Shift register and the SDR / RTI period counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_r      <= {SR_W{1'b0}};
      bit_cnt_r <= {BIT_W{1'b0}};
      rti_cnt_r <= {RTI_W{1'b0}};
    end else begin
      if (accept_s)                       sr_r <= cmd_data;
      else if (sample_s && state_r == SDR) sr_r <= {sample_bit_s, sr_r[SR_W-1:1]};
      if (state_r != SDR)  bit_cnt_r <= {BIT_W{1'b0}};
      else if (drive_s)    bit_cnt_r <= bit_cnt_r + BIT_W'(1);
      if (state_r != RTI)  rti_cnt_r <= {RTI_W{1'b0}};
      else if (drive_s)    rti_cnt_r <= rti_cnt_r + RTI_W'(1);
    end
  end

  // Response holding register.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= {SR_W{1'b0}};
    end else if (state_r == RTI && state_nxt_s == RESP) begin
      rsp_valid_r <= 1'b1;
      rsp_data_r  <= sr_r;
    end else if (rsp_ready) begin
      rsp_valid_r <= 1'b0;
    end
  end

  assign cmd_ready      = cmd_ready_s;
  assign rsp_valid      = rsp_valid_r;
  assign rsp_data       = rsp_data_r;
  assign tdi            = tdi_r;
  assign ir_in          = ir_r;
  assign vs_uir         = uir_r;
  assign vs_cdr         = cdr_r;
  assign vs_sdr         = sdr_r;
  assign vs_udr         = udr_r;
  assign jtag_state_rti = rti_r;
  assign busy           = busy_r;

endmodule

// File: tb/tb_tmc_dbg_scan_master.sv
// Bench for tmc_dbg_scan_master: default instance plus a TCK_DIV=1/RTI_CYCLES=1 instance,
// driven against a behavioural virtual-JTAG slave model.
module tb_tmc_dbg_scan_master;
  import tmc_dbg_scan_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic [1:0] cmd_valid_v, cmd_ready_v, rsp_valid_v, rsp_ready_v;
  logic [1:0] tck_v, tdi_v, tdo_v, uir_v, cdr_v, sdr_v, udr_v, rti_v, busy_v;
  logic [1:0] cmd_ir;
  logic [37:0] cmd_data;
  logic [37:0] rsp_data_v [2];
  logic [1:0]  ir_in_v [2];
`ifdef TMC_DBG_SCAN_LOOPBACK_EN
  logic [1:0] lb_v;
`endif

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  tmc_dbg_scan_master u0 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid_v[0]), .cmd_ready(cmd_ready_v[0]),
    .cmd_ir(cmd_ir), .cmd_data(cmd_data), .rsp_valid(rsp_valid_v[0]), .rsp_ready(rsp_ready_v[0]),
    .rsp_data(rsp_data_v[0]),
`ifdef TMC_DBG_SCAN_LOOPBACK_EN
    .loopback(lb_v[0]),
`endif
    .tck(tck_v[0]), .tdi(tdi_v[0]), .tdo(tdo_v[0]), .ir_in(ir_in_v[0]),
    .vs_uir(uir_v[0]), .vs_cdr(cdr_v[0]), .vs_sdr(sdr_v[0]), .vs_udr(udr_v[0]),
    .jtag_state_rti(rti_v[0]), .busy(busy_v[0])
  );

  tmc_dbg_scan_master #(.TCK_DIV(1), .RTI_CYCLES(1)) u1 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid_v[1]), .cmd_ready(cmd_ready_v[1]),
    .cmd_ir(cmd_ir), .cmd_data(cmd_data), .rsp_valid(rsp_valid_v[1]), .rsp_ready(rsp_ready_v[1]),
    .rsp_data(rsp_data_v[1]),
`ifdef TMC_DBG_SCAN_LOOPBACK_EN
    .loopback(lb_v[1]),
`endif
    .tck(tck_v[1]), .tdi(tdi_v[1]), .tdo(tdo_v[1]), .ir_in(ir_in_v[1]),
    .vs_uir(uir_v[1]), .vs_cdr(cdr_v[1]), .vs_sdr(sdr_v[1]), .vs_udr(udr_v[1]),
    .jtag_state_rti(rti_v[1]), .busy(busy_v[1])
  );

  // Slave model state: the active instance, its shift register and scan logs.
  logic        act;
  logic [37:0] slv;
  logic        force1;
  logic        tck_q, prev_busy;
  logic [7:0]  prev_out;
  int          onehot_err, drive_err;
  int          strobe_q[$];
  logic        tdi_q[$];

  // Slave: on every tck rise in shift-DR, capture tdi and present the next tdo bit.
  always @(negedge clk) begin
    logic [4:0] stb;
    logic [7:0] cur;
    stb = {uir_v[act], cdr_v[act], sdr_v[act], udr_v[act], rti_v[act]};
    cur = {stb, tdi_v[act], ir_in_v[act]};
    if (!reset) begin
      if (busy_v[act] && $countones(stb) != 1) onehot_err++;
      if (cur != prev_out && prev_busy && !(tck_q && !tck_v[act])) drive_err++;
      if (tck_v[act] && !tck_q) begin
        strobe_q.push_back(int'(stb));
        if (sdr_v[act]) begin
          tdi_q.push_back(tdi_v[act]);
          slv = {tdi_v[act], slv[37:1]};
        end
      end
    end
    prev_out  = cur;
    prev_busy = busy_v[act];
    tck_q     = tck_v[act];
    tdo_v     = 2'b00;
    tdo_v[act] = force1 ? 1'b1 : slv[0];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected strobe at the k-th tck rise: UIR, CDR, 38 x SDR, UDR, then RTI.
  function automatic int exp_strobe(input int k);
    if (k == 0)       return 16;
    else if (k == 1)  return 8;
    else if (k < 40)  return 4;
    else if (k == 40) return 2;
    else              return 1;
  endfunction

  task automatic start_logs(input logic d, input logic [37:0] pre, input bit lb);
    act = d;
    slv = pre;
    force1 = lb;
    strobe_q.delete();
    tdi_q.delete();
    onehot_err = 0;
    drive_err = 0;
  endtask

  task automatic run_scan(input logic d, input logic [1:0] ir, input logic [37:0] data,
                          input logic [37:0] pre, input bit lb, input bit consume, input int rti);
    int n, lat, seq_err;
    logic [37:0] exp_rsp, tdi_seen;
    lat = 1 + (38 + 3 + rti) * 2 * (d ? 1 : 2);
    exp_rsp = lb ? data : pre;
    @(negedge clk);
    start_logs(d, pre, lb);
    cmd_ir = ir;
    cmd_data = data;
    cmd_valid_v[d] = 1'b1;
`ifdef TMC_DBG_SCAN_LOOPBACK_EN
    lb_v[d] = lb;
`endif
    n = 0;
    while (cmd_ready_v[d] !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_ready_before_accept", 64'(cmd_ready_v[d]), 64'(1));
    n = 0;
    do begin
      @(negedge clk);
      n++;
      cmd_valid_v[d] = 1'b0;
    end while (rsp_valid_v[d] !== 1'b1 && n < lat + 50);
    chk("rsp_latency", 64'(n), 64'(lat));
    chk("rsp_data", 64'(rsp_data_v[d]), 64'(exp_rsp));
    chk("ir_in_held", 64'(ir_in_v[d]), 64'(ir));
    chk("busy_after_scan", 64'(busy_v[d]), 64'(0));
    chk("strobe_count", 64'(strobe_q.size()), 64'(41 + rti));
    seq_err = 0;
    foreach (strobe_q[k]) if (strobe_q[k] != exp_strobe(k)) seq_err++;
    chk("strobe_order", 64'(seq_err), 64'(0));
    tdi_seen = 38'h0;
    for (int i = 0; i < 38; i++) if (i < tdi_q.size()) tdi_seen[i] = tdi_q[i];
    chk("tdi_bit_count", 64'(tdi_q.size()), 64'(38));
    chk("tdi_lsb_first", 64'(tdi_seen), 64'(data));
    chk("onehot_strobes", 64'(onehot_err), 64'(0));
    chk("change_on_low_phase", 64'(drive_err), 64'(0));
    if (consume) begin
      rsp_ready_v[d] = 1'b1;
      @(negedge clk);
      rsp_ready_v[d] = 1'b0;
      chk("rsp_valid_after_handshake", 64'(rsp_valid_v[d]), 64'(0));
    end
  endtask

  initial begin
    logic [37:0] held, pre2;
    int n, bp_err, late;
    reset = 1'b1;
    cmd_valid_v = 2'b00;
    rsp_ready_v = 2'b00;
    cmd_ir = IR_OCIMEM;
    cmd_data = 38'h0;
    act = 1'b0;
    slv = 38'h0;
    force1 = 1'b0;
`ifdef TMC_DBG_SCAN_LOOPBACK_EN
    lb_v = 2'b00;
`endif
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("idle_strobes_tck_busy", 64'({uir_v, cdr_v, sdr_v, udr_v, rti_v, busy_v, tck_v, tdi_v}), 64'(0));
    chk("idle_cmd_ready", 64'(cmd_ready_v), 64'(2'b11));
    chk("idle_rsp_valid", 64'(rsp_valid_v), 64'(0));

    // Directed scan left unconsumed, then 50 clks of backpressure with a command pending.
    run_scan(1'b0, IR_BREAK, 38'h2A_5555_AAAA, 38'h15_DEAD_BEEF, 1'b0, 1'b0, 2);
    held = rsp_data_v[0];
    pre2 = {6'($urandom), 32'($urandom)};
    start_logs(1'b0, pre2, 1'b0);
    cmd_ir = IR_TRACEMEM;
    cmd_data = {6'($urandom), 32'($urandom)};
    cmd_valid_v[0] = 1'b1;
    bp_err = 0;
    repeat (50) begin
      @(negedge clk);
      if (cmd_ready_v[0] !== 1'b0 || rsp_valid_v[0] !== 1'b1 ||
          rsp_data_v[0] !== held || busy_v[0] !== 1'b0) bp_err++;
    end
    chk("backpressure_hold", 64'(bp_err), 64'(0));
    rsp_ready_v[0] = 1'b1;
    @(negedge clk);
    rsp_ready_v[0] = 1'b0;
    cmd_valid_v[0] = 1'b0;
    chk("handshake_clears_rsp", 64'(rsp_valid_v[0]), 64'(0));
    chk("handshake_accepts_cmd", 64'({busy_v[0], ir_in_v[0]}), 64'({1'b1, IR_TRACEMEM}));
    n = 1;
    while (rsp_valid_v[0] !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("second_rsp_latency", 64'(n), 64'(173));
    chk("second_rsp_data", 64'(rsp_data_v[0]), 64'(pre2));
    rsp_ready_v[0] = 1'b1;
    @(negedge clk);
    rsp_ready_v[0] = 1'b0;

    // Reset 60 clks into a scan aborts it.
    start_logs(1'b0, 38'h3F_0F0F_0F0F, 1'b0);
    cmd_ir = IR_TRACECTRL;
    cmd_data = 38'h12_3456_789A;
    cmd_valid_v[0] = 1'b1;
    @(negedge clk);
    cmd_valid_v[0] = 1'b0;
    repeat (59) @(negedge clk);
    chk("mid_scan_in_sdr", 64'(sdr_v[0]), 64'(1));
    reset = 1'b1;
    @(negedge clk);
    chk("reset_outputs", 64'({uir_v[0], cdr_v[0], sdr_v[0], udr_v[0], rti_v[0], busy_v[0],
                              tck_v[0], tdi_v[0], ir_in_v[0], rsp_valid_v[0]}), 64'(0));
    chk("reset_cmd_ready", 64'(cmd_ready_v[0]), 64'(1));
    reset = 1'b0;
    late = 0;
    repeat (200) begin
      @(negedge clk);
      if (rsp_valid_v[0] !== 1'b0 || busy_v[0] !== 1'b0) late++;
    end
    chk("no_rsp_after_abort", 64'(late), 64'(0));
    run_scan(1'b0, IR_OCIMEM, 38'h00_FFFF_0001, 38'h2B_C0DE_1234, 1'b0, 1'b1, 2);

    // Fast instance: tck period 2 clks, one RTI period.
    run_scan(1'b1, IR_BREAK, 38'h2A_5555_AAAA, 38'h15_DEAD_BEEF, 1'b0, 1'b1, 1);

`ifdef TMC_DBG_SCAN_LOOPBACK_EN
    run_scan(1'b0, IR_OCIMEM, 38'h0, 38'h15_DEAD_BEEF, 1'b1, 1'b1, 2);
`endif

    for (int k = 0; k < 6; k++) begin
      bit lb;
`ifdef TMC_DBG_SCAN_LOOPBACK_EN
      lb = 1'($urandom);
`else
      lb = 1'b0;
`endif
      run_scan(k[0], 2'($urandom), {6'($urandom), 32'($urandom)}, {6'($urandom), 32'($urandom)},
               lb, 1'b1, k[0] ? 1 : 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
